gerenciador_fila: RTL and testbench

GERENCIADOR_FILA -- requirements
Module: gerenciador_fila

---
 rtl/fila_pkg.sv | 23 ++
 rtl/fila_between_cmp.sv | 48 ++++
 rtl/gerenciador_fila.sv | 183 ++++++++++++++++++
 tb/tb_gerenciador_fila.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fila_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fila_pkg
// Description : Shared types and constants for the elevator floor-call queue
//               controller (state encoding, queue depth, field widths).
// Revision    : 1.0 - initial release
// ============================================================================
package fila_pkg;

    localparam int              DEPTH       = 16;
    localparam int              CNT_W       = 5;
    localparam int              FLOOR_W     = 4;
    localparam logic [FLOOR_W-1:0] EMPTY_FLOOR = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_WRITE = 2'd2,
        ST_SHIFT = 2'd3
    } fila_state_t;

endpackage
`default_nettype wire

// File: rtl/fila_between_cmp.sv
`default_nettype none
// ============================================================================
// Module      : fila_between_cmp
// Description : Combinational decision for one queue slot during a scan:
//               drop the request, append at the empty slot, fit it between
//               prev and cur, or move on to the next slot.
// Revision    : 1.0 - initial release
// ============================================================================
module fila_between_cmp
    import fila_pkg::*;
(
    input  logic [FLOOR_W-1:0] f,
    input  logic [FLOOR_W-1:0] prev,
    input  logic [FLOOR_W-1:0] cur,
    input  logic               first,
    output logic               drop,
    output logic               append,
    output logic               fit,
    output logic               advance
);

    logic w_dup;
    logic w_between;

    // A floor already adjacent to this position (or the reserved marker) is
    // redundant. At slot 0 "prev" is the cabin itself, which is not a stop.
    assign w_dup     = (f == EMPTY_FLOOR) || (f == cur) || (!first && (f == prev));
    assign w_between = ((prev < f) && (f < cur)) || ((cur < f) && (f < prev));

    // Priority-ordered one-hot decision for the slot under examination
    always_comb begin
        drop    = 1'b0;
        append  = 1'b0;
        fit     = 1'b0;
        advance = 1'b0;
        if (w_dup) begin
            drop = 1'b1;
        end else if (cur == EMPTY_FLOOR) begin
            append = 1'b1;
        end else if (w_between) begin
            fit = 1'b1;
        end else begin
            advance = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gerenciador_fila.sv
`default_nettype none
// ============================================================================
// Module      : gerenciador_fila
// Description : Floor-call queue controller. Scans an external queue RAM one
//               slot per cycle to insert a new call on the travel path, and
//               pops the head when the elevator arrives at it.
// Revision    : 1.0 - initial release
// ============================================================================
module gerenciador_fila
    import fila_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [FLOOR_W-1:0] req_floor,
    output logic               req_ready,
    input  logic [FLOOR_W-1:0] cur_floor,
    input  logic               arrive,
    input  logic [FLOOR_W-1:0] ram_q,
    input  logic [FLOOR_W-1:0] ram_sec,
    input  logic [FLOOR_W-1:0] ram_sec_prev,
    output logic [3:0]         ram_addr,
    output logic [3:0]         ram_addr_sec,
    output logic [3:0]         ram_addr_sec_prev,
    output logic [FLOOR_W-1:0] ram_data,
    output logic               ram_we,
    output logic               ram_weT,
    output logic               ram_shift,
    output logic               ram_fit,
    output logic [FLOOR_W-1:0] next_floor,
    output logic [CNT_W-1:0]   count,
    output logic               done,
    output logic               dropped
);

    fila_state_t        r_state;
    fila_state_t        w_state_next;
    logic [3:0]         r_idx;
    logic [FLOOR_W-1:0] r_f;
    logic [CNT_W-1:0]   r_count;
    logic               r_arrive_pend;
    logic               r_wr_fit;
    logic               r_done;
    logic               r_dropped;

    logic [FLOOR_W-1:0] w_prev;
    logic               w_drop;
    logic               w_append;
    logic               w_fit;
    logic               w_advance;
    logic               w_head_hit;
    logic               w_service;
    logic               w_xfer;
    logic               w_scan_decides;

    // At slot 0 the predecessor on the path is the cabin position.
    assign w_prev         = (r_idx == 4'd0) ? cur_floor : ram_sec_prev;
    assign w_head_hit     = (r_count != '0) && (ram_q == cur_floor);
    assign w_service      = arrive || r_arrive_pend;
    assign w_xfer         = req_valid && req_ready;
    assign w_scan_decides = (r_state == ST_SCAN) && (w_drop || w_append || w_fit);

    // A pending arrival is handled before new requests; a same-cycle arrival
    // at the head pre-empts the request so the shift goes first.
    assign req_ready = (r_state == ST_IDLE) && (r_count < CNT_W'(DEPTH))
                     && !r_arrive_pend && !(arrive && w_head_hit);

    fila_between_cmp u_cmp (
        .f       (r_f),
        .prev    (w_prev),
        .cur     (ram_sec),
        .first   (r_idx == 4'd0),
        .drop    (w_drop),
        .append  (w_append),
        .fit     (w_fit),
        .advance (w_advance)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decision
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_service && w_head_hit) begin
                    w_state_next = ST_SHIFT;
                end else if (w_xfer) begin
                    w_state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_drop) begin
                    w_state_next = ST_IDLE;
                end else if (w_append || w_fit) begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: w_state_next = ST_IDLE;
            ST_SHIFT: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // RAM addresses, write data and strobes derived from the current state
    always_comb begin
        ram_addr_sec      = 4'd0;
        ram_addr_sec_prev = 4'd0;
        ram_data          = EMPTY_FLOOR;
        ram_weT           = 1'b0;
        ram_fit           = 1'b0;
        ram_shift         = 1'b0;
        unique case (r_state)
            ST_SCAN: begin
                ram_addr_sec      = r_idx;
                ram_addr_sec_prev = (r_idx == 4'd0) ? 4'd0 : (r_idx - 4'd1);
            end
            ST_WRITE: begin
                ram_addr_sec = r_idx;
                ram_data     = r_f;
                ram_weT      = !r_wr_fit;
                ram_fit      = r_wr_fit;
            end
            ST_SHIFT: ram_shift = 1'b1;
            default: ;
        endcase
    end

    // Request datapath: latched floor, scan index, occupancy, pending arrival
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx         <= 4'd0;
            r_f           <= EMPTY_FLOOR;
            r_count       <= '0;
            r_arrive_pend <= 1'b0;
            r_wr_fit      <= 1'b0;
            r_done        <= 1'b0;
            r_dropped     <= 1'b0;
        end else begin
            r_done    <= w_scan_decides;
            r_dropped <= (r_state == ST_SCAN) && w_drop;

            if (w_xfer && !(w_service && w_head_hit)) begin
                r_f   <= req_floor;
                r_idx <= 4'd0;
            end else if ((r_state == ST_SCAN) && w_advance && (r_idx != 4'(DEPTH - 1))) begin
                r_idx <= r_idx + 4'd1;
            end

            if (r_state == ST_SCAN) begin
                r_wr_fit <= w_fit;
            end

            if (r_state == ST_WRITE) begin
                r_count <= r_count + CNT_W'(1);
            end else if (r_state == ST_SHIFT) begin
                r_count <= r_count - CNT_W'(1);
            end

            if (r_state == ST_IDLE) begin
                r_arrive_pend <= 1'b0;
            end else if (arrive) begin
                r_arrive_pend <= 1'b1;
            end
        end
    end

    assign ram_addr   = 4'd0;
    assign ram_we     = 1'b0;
    assign count      = r_count;
    assign done       = r_done;
    assign dropped    = r_dropped;
    assign next_floor = (r_count == '0) ? EMPTY_FLOOR : ram_q;

endmodule
`default_nettype wire

// File: tb/tb_gerenciador_fila.sv
`default_nettype none
// ============================================================================
// Module      : tb_gerenciador_fila
// Description : Directed self-checking bench for gerenciador_fila with a
//               behavioural model of the external queue RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gerenciador_fila;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_floor = 4'd0;
    logic       req_ready;
    logic [3:0] cur_floor = 4'd0;
    logic       arrive = 1'b0;
    logic [3:0] ram_q, ram_sec, ram_sec_prev;
    logic [3:0] ram_addr, ram_addr_sec, ram_addr_sec_prev, ram_data;
    logic       ram_we, ram_weT, ram_shift, ram_fit;
    logic [3:0] next_floor;
    logic [4:0] count;
    logic       done, dropped;

    logic       mem_clr = 1'b1;
    logic [3:0] mem [16];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gerenciador_fila dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_floor         (req_floor),
        .req_ready         (req_ready),
        .cur_floor         (cur_floor),
        .arrive            (arrive),
        .ram_q             (ram_q),
        .ram_sec           (ram_sec),
        .ram_sec_prev      (ram_sec_prev),
        .ram_addr          (ram_addr),
        .ram_addr_sec      (ram_addr_sec),
        .ram_addr_sec_prev (ram_addr_sec_prev),
        .ram_data          (ram_data),
        .ram_we            (ram_we),
        .ram_weT           (ram_weT),
        .ram_shift         (ram_shift),
        .ram_fit           (ram_fit),
        .next_floor        (next_floor),
        .count             (count),
        .done              (done),
        .dropped           (dropped)
    );

    assign ram_q        = mem[ram_addr];
    assign ram_sec      = mem[ram_addr_sec];
    assign ram_sec_prev = mem[ram_addr_sec_prev];

    // Queue RAM model: tail write, insert-with-shift-up, pop-head shift-down
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 4'd0;
        end else if (ram_shift) begin
            for (int i = 0; i < 15; i++) mem[i] <= mem[i+1];
            mem[15] <= 4'd0;
        end else if (ram_fit) begin
            for (int i = 1; i < 16; i++) if (i > int'(ram_addr_sec)) mem[i] <= mem[i-1];
            mem[ram_addr_sec] <= ram_data;
        end else if (ram_weT) begin
            mem[ram_addr_sec] <= ram_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        mem_clr = 1'b1;
        step();
        step();
        rst_n   = 1'b1;
        mem_clr = 1'b0;
        step();
    endtask

    // Issue one request; lat counts cycles from transfer edge to done.
    // The bench ends one cycle after done so any RAM write has landed.
    task automatic do_req(input logic [3:0] fl, input int arrive_at,
                          output int lat, output bit dr, output bit wt, output bit ft);
        int n;
        dr = 1'b0; wt = 1'b0; ft = 1'b0;
        req_floor = fl;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 40) begin
            step();
            n++;
        end
        if (!req_ready) check("ready_timeout", 0, 1);
        step();
        req_valid = 1'b0;
        req_floor = 4'd0;
        lat = 1;
        while (lat <= 20) begin
            arrive = (lat == arrive_at);
            if (ram_weT) wt = 1'b1;
            if (ram_fit) ft = 1'b1;
            if (done) begin
                dr = dropped;
                break;
            end
            step();
            lat++;
        end
        arrive = 1'b0;
        if (lat > 20) check("done_timeout", 0, 1);
        step();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  dr, wt, ft, saw_done;

        // Reset state
        #3;
        check("rst_count",   count, 0);
        check("rst_next",    next_floor, 0);
        check("rst_done",    {done, dropped}, 0);
        check("rst_strobes", {ram_we, ram_weT, ram_shift, ram_fit}, 0);
        check("rst_addr",    {ram_addr, ram_addr_sec, ram_addr_sec_prev, ram_data}, 0);
        check("rst_ready",   req_ready, 1);
        step();
        rst_n   = 1'b1;
        mem_clr = 1'b0;
        step();

        // Append to empty queue
        cur_floor = 4'd2;
        do_req(4'd7, 0, lat, dr, wt, ft);
        check("app_lat", lat, 2);
        check("app_weT", {wt, ft, dr}, 3'b100);
        check("app_count", count, 1);
        check("app_next", next_floor, 7);

        // Fit before head: [9] + 5 -> [5,9]
        do_reset();
        cur_floor = 4'd2;
        do_req(4'd9, 0, lat, dr, wt, ft);
        do_req(4'd5, 0, lat, dr, wt, ft);
        check("fit_lat", lat, 2);
        check("fit_kind", {wt, ft, dr}, 3'b010);
        check("fit_count", count, 2);
        check("fit_next", next_floor, 5);
        check("fit_mem1", mem[1], 9);

        // Duplicate of entry 1 is dropped at idx 1
        do_req(4'd9, 0, lat, dr, wt, ft);
        check("drop_lat", lat, 3);
        check("drop_flag", dr, 1);
        check("drop_nostrobe", {wt, ft}, 0);
        check("drop_count", count, 2);

        // Arrival at head with a simultaneous request: shift wins
        cur_floor = 4'd5;
        arrive    = 1'b1;
        req_valid = 1'b1;
        req_floor = 4'd3;
        #1;
        check("coll_ready", req_ready, 0);
        step();
        arrive    = 1'b0;
        req_valid = 1'b0;
        check("shift_strobe", ram_shift, 1);
        step();
        check("shift_strobe_off", ram_shift, 0);
        check("shift_count", count, 1);
        check("shift_next", next_floor, 9);

        // Arrival during a 3-slot scan is deferred until after done
        cur_floor = 4'd2;
        do_req(4'd12, 0, lat, dr, wt, ft);
        check("app2_lat", lat, 3);
        cur_floor = 4'd9;
        do_req(4'd15, 2, lat, dr, wt, ft);
        check("app3_lat", lat, 4);
        check("app3_kind", {wt, ft, dr}, 3'b100);
        check("pend_idle_shift", ram_shift, 0);
        check("pend_idle_ready", req_ready, 0);
        step();
        check("pend_shift", ram_shift, 1);
        step();
        check("pend_count", count, 2);
        check("pend_next", next_floor, 12);

        // Fill to 16 entries, then free one slot by arriving at the head
        do_reset();
        cur_floor = 4'd1;
        do_req(4'd15, 0, lat, dr, wt, ft);
        for (int fl = 14; fl >= 2; fl--) begin
            do_req(4'(fl), 0, lat, dr, wt, ft);
            check("fill_lat", lat, 2);
        end
        cur_floor = 4'd15;
        do_req(4'd8, 0, lat, dr, wt, ft);
        check("fill_fit8", {wt, ft, dr}, 3'b010);
        do_req(4'd12, 0, lat, dr, wt, ft);
        check("full_count", count, 16);
        check("full_ready", req_ready, 0);
        check("full_next", next_floor, 12);
        cur_floor = 4'd12;
        arrive    = 1'b1;
        step();
        arrive    = 1'b0;
        check("full_shift", ram_shift, 1);
        check("full_shift_ready", req_ready, 0);
        step();
        check("after_shift_ready", req_ready, 1);
        check("after_shift_count", count, 15);
        check("after_shift_next", next_floor, 8);

        // Reset in the middle of a scan at idx 4
        do_reset();
        cur_floor = 4'd1;
        do_req(4'd5, 0, lat, dr, wt, ft);
        do_req(4'd4, 0, lat, dr, wt, ft);
        do_req(4'd3, 0, lat, dr, wt, ft);
        do_req(4'd2, 0, lat, dr, wt, ft);
        check("pre_count", count, 4);
        req_floor = 4'd9;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (4) step();
        check("scan_idx4", ram_addr_sec, 4);
        rst_n = 1'b0;
        #1;
        check("midrst_addr", {ram_addr_sec, ram_addr_sec_prev, ram_data}, 0);
        check("midrst_out", {count, done, dropped, ram_weT, ram_fit, ram_shift}, 0);
        saw_done = 1'b0;
        repeat (3) begin
            step();
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        step();
        if (done) saw_done = 1'b1;
        check("midrst_nodone", saw_done, 0);
        check("midrst_ready", req_ready, 1);
        do_req(4'd7, 0, lat, dr, wt, ft);
        check("post_rst_lat", lat, 6);
        check("post_rst_kind", {wt, ft, dr}, 3'b100);
        check("post_rst_count", count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
